crc8_serial_checker: RTL
========================

Name: crc8_serial_checker

Overview:
- Bit-serial CRC checker/generator built around the XOR-feedback datapath.
- Consumes a framed serial bit stream, MSB-first, one bit per accepted cycle, and accumulates a CRC remainder through an LFSR.
- At end of frame it reports the remainder and a pass flag, i.e. whether the frame including its appended CRC leaves a zero remainder.
- Sits downstream of the XOR primitives and feeds link-level frame-accept logic.

Parameters:
- WIDTH, 8: CRC register width in bits.
- POLY, 8'h07: generator polynomial, implicit top bit omitted.
- INIT, 8'h00: remainder value loaded at frame start.
- CNT_W, 16: width of the accepted-bit counter.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: begin new frame; loads INIT and clears the counter.
- in_valid, input, 1: in_bit is valid this cycle.
- in_bit, input, 1: serial data bit, MSB-first.
- in_last, input, 1: qualifies in_bit as the final bit of the frame; ignored unless in_valid=1.
- busy, output, 1: high while in RUN.
- done, output, 1: one-cycle pulse when the frame result is valid.
- crc_ok, output, 1: remainder==0; valid only when done=1, and 0 otherwise.
- crc_out, output, WIDTH: final remainder; holds until the next start.
- bit_count, output, CNT_W: bits accepted in the current or most recent frame; saturates at all-ones.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, crc register=INIT, busy=0, done=0, crc_ok=0, crc_out=0, bit_count=0. Reset mid-frame abandons the frame with no done pulse.
- Update rule for every accepted bit: fb = crc[WIDTH-1] ^ in_bit; crc_next = (crc << 1) ^ (fb ? POLY : 0), truncated to WIDTH.
- IDLE:
  - in_valid is ignored.
  - start=1 -> crc=INIT, bit_count=0, go to RUN.
- RUN (busy=1):
  - start=1 has priority: it restarts the frame (crc=INIT, bit_count=0, stay in RUN), and any in_valid on that cycle is dropped.
  - Otherwise in_valid=1 -> apply the update rule and increment bit_count, saturating at 2^CNT_W-1.
  - in_valid=1 with in_last=1 -> apply the update, then go to DONE; crc_out=crc_next is registered on the same edge.
  - in_valid=0 -> crc holds.
- DONE (one cycle):
  - done=1, crc_ok=(crc_out==0), busy=0, and input bits are ignored.
  - Next state is IDLE; if start=1 in DONE, go directly to RUN with INIT loaded.
- Latency: done asserts exactly 1 cycle after the edge that accepts the in_last bit.
- Back-to-back frames: the minimum gap is the DONE cycle; start may be asserted in that cycle.
- A zero-length frame is not possible, since the last bit must carry in_valid.
- crc_out and bit_count persist after DONE until the next start or reset.
- Fully synchronous datapath; the only asynchronous path is rst_n.

Test Plan:
- Reset then frame 8'h00 (8 bits, last on the 8th) -> done pulse 1 cycle after the last bit; crc_out=8'h00, crc_ok=1, bit_count=8.
- Frame 8'h01 -> crc_out=8'h07, crc_ok=0. Frame 8'h01 followed by 8'h07 (16 bits) -> crc_out=8'h00, crc_ok=1, bit_count=16.
- Frame ASCII "123456789" (72 bits) -> crc_out=8'hF4. The same frame followed by 8'hF4 -> crc_ok=1.
- Frame 8'hFF with in_valid toggled randomly (gaps) -> crc_out=8'hF3. Gaps do not change the result.
- Start reasserted after 5 bits of a frame, then 8'hFF -> restart: crc_out=8'hF3, bit_count=8. Start asserted during the DONE cycle -> busy=1 the next cycle with no idle gap.
- rst_n pulled low mid-frame, asynchronously between edges -> outputs go to 0 immediately and no done pulse follows. A subsequent frame 8'h01 -> crc_out=8'h07.

Source files
------------

// File: rtl/crc8_serial_checker.sv
// ---------------------------------------------------------------------------
// crc8_serial_checker
//
// Bit-serial CRC checker/generator. A frame is opened with `start`, then
// bits arrive MSB-first, one per cycle in which in_valid=1. Each accepted
// bit is folded into an LFSR-style remainder register. The bit flagged with
// in_last closes the frame. One cycle later the bench sees `done` for one
// cycle, together with the final remainder on crc_out. crc_ok is high when
// that remainder is zero, which is the case when the frame already carries
// its own CRC.
//
// Handshake: there is no backpressure. Any bit presented with in_valid=1
// while the block is in RUN (and start=0) is consumed on that rising edge.
// Bits presented in IDLE or DONE, or together with start, are dropped.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      open / restart a frame (loads INIT, clears count)
//   in_valid   in   1      in_bit is valid this cycle
//   in_bit     in   1      serial data bit, MSB-first
//   in_last    in   1      marks the final bit; only meaningful with in_valid
//   busy       out  1      high while a frame is in progress (RUN)
//   done       out  1      one-cycle pulse when crc_out/crc_ok are valid
//   crc_ok     out  1      remainder is zero; only high together with done
//   crc_out    out  WIDTH  final remainder of the most recent frame
//   bit_count  out  CNT_W  bits accepted in current/last frame, saturating
// ---------------------------------------------------------------------------
module crc8_serial_checker #(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = 8'h07,
  parameter logic [WIDTH-1:0] INIT = 8'h00,
  parameter int              CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic [WIDTH-1:0] crc_out,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] crc;
  logic [WIDTH-1:0] crc_next;
  logic             fb;

  // One LFSR step: the bit shifted out of the top is XORed with the incoming
  // bit; when that feedback is set the polynomial is folded back in.
  always_comb begin
    fb       = crc[WIDTH-1] ^ in_bit;
    crc_next = {crc[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  // busy is a pure decode of the state register, so it is glitch-free and
  // changes on the same edge as the state.
  assign busy = (state == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      crc       <= INIT;
      done      <= 1'b0;
      crc_ok    <= 1'b0;
      crc_out   <= '0;
      bit_count <= '0;
    end else begin
      // done/crc_ok are single-cycle pulses; they are only raised on the
      // edge that accepts the last bit.
      done   <= 1'b0;
      crc_ok <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            crc       <= INIT;
            bit_count <= '0;
            crc_out   <= '0;
            state     <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (start) begin
            // Restart wins over any bit offered on the same cycle.
            crc       <= INIT;
            bit_count <= '0;
            crc_out   <= '0;
          end else if (in_valid) begin
            crc <= crc_next;
            if (bit_count != CNT_MAX) begin
              bit_count <= bit_count + CNT_W'(1);
            end
            if (in_last) begin
              crc_out <= crc_next;
              crc_ok  <= (crc_next == '0);
              done    <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          // Result cycle. A start here chains straight into the next frame.
          if (start) begin
            crc       <= INIT;
            bit_count <= '0;
            crc_out   <= '0;
            state     <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
